// File: rtl/updown_counter_core.sv
// ---------------------------------------------------------------------------
// UpdownCounterCore
//
// Button-controlled decimal up/down counter that feeds the 14-bit value port
// of the 4-digit FND display controller sitting right after it. The count
// runs from 0 to MAX_COUNT and wraps in both directions. Three raw push-button
// levels come in. Each one is synchronised and turned into a single-cycle
// rising-edge pulse. A small STOP/RUN/CLEAR state machine decides what the
// pulses do. An internal divider paces the counting while running.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   COUNT_HZ   count-step rate in Hz
//   DIV        clocks per count step (defaults to CLK_FREQ/COUNT_HZ, >= 2)
//   MAX_COUNT  wrap value, must fit in 14 bits
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   i_btn_run    in   1   raw level, rising edge toggles STOP <-> RUN
//   i_btn_clear  in   1   raw level, rising edge zeroes the count and stops
//   i_btn_mode   in   1   raw level, rising edge toggles up/down direction
//   o_count      out  14  current count, binary 0..MAX_COUNT
//   o_run        out  1   1 while in the RUN state
//   o_mode       out  1   0 = counting up, 1 = counting down
// ---------------------------------------------------------------------------
module updown_counter_core #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned COUNT_HZ  = 10,
    parameter int unsigned DIV       = CLK_FREQ / COUNT_HZ,
    parameter int unsigned MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btn_run,
    input  logic        i_btn_clear,
    input  logic        i_btn_mode,
    output logic [13:0] o_count,
    output logic        o_run,
    output logic        o_mode
);

    // The divider only has to reach DIV-1, so it is sized from DIV. A
    // degenerate DIV still gets a 1-bit divider so the widths stay legal.
    localparam int unsigned      DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [13:0]      COUNT_MAX = 14'(MAX_COUNT);

    // CLEAR lasts exactly one cycle. It gives the zeroed count and divider a
    // clean settle point before control returns to STOP.
    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2
    } CounterState;

    // Bit 0 = run, bit 1 = clear, bit 2 = mode. All three buttons share one
    // vector so that they travel through identical pipelines.
    logic [2:0] btnRaw;
    logic [2:0] btnSyncA_q;
    logic [2:0] btnSyncB_q;
    logic [2:0] btnPrev_q;
    logic [2:0] btnPulse;

    logic runPulse;
    logic clearPulse;
    logic modePulse;

    CounterState      state_q;
    logic [13:0]      count_q;
    logic [DIV_W-1:0] divider_q;
    logic             run_q;
    logic             mode_q;

    logic             tick;
    logic [13:0]      countStep_d;
    logic [DIV_W-1:0] dividerInc_d;

    assign btnRaw = {i_btn_mode, i_btn_clear, i_btn_run};

    // Two flops bring the raw levels into the clock domain. The third flop
    // remembers the previous synchronised level, so a rising edge appears as
    // a one-cycle pulse no matter how long the button is held. Bouncing is
    // removed upstream, so no filtering is done here.
    always_ff @(posedge clk) begin
        if (rst) begin
            btnSyncA_q <= 3'b000;
            btnSyncB_q <= 3'b000;
            btnPrev_q  <= 3'b000;
        end else begin
            btnSyncA_q <= btnRaw;
            btnSyncB_q <= btnSyncA_q;
            btnPrev_q  <= btnSyncB_q;
        end
    end

    // A pulse is high in the cycle where the synchronised level has just
    // gone high but the remembered level is still low.
    assign btnPulse   = btnSyncB_q & ~btnPrev_q;
    assign runPulse   = btnPulse[0];
    assign clearPulse = btnPulse[1];
    assign modePulse  = btnPulse[2];

    // The divider fires a tick in the last cycle of each step period. Only a
    // running counter ticks. A held divider value in STOP must not fire.
    assign tick         = (state_q == RUN) && (divider_q == DIV_LAST);
    assign dividerInc_d = divider_q + DIV_W'(1);

    // Candidate value for the next step in the current direction, with a
    // wrap at both ends. The direction is taken from the registered mode, so
    // a mode pulse in the same cycle as a tick only affects later steps.
    always_comb begin
        countStep_d = count_q;
        if (mode_q) begin
            if (count_q == 14'd0) begin
                countStep_d = COUNT_MAX;
            end else begin
                countStep_d = count_q - 14'd1;
            end
        end else begin
            if (count_q >= COUNT_MAX) begin
                countStep_d = 14'd0;
            end else begin
                countStep_d = count_q + 14'd1;
            end
        end
    end

    // Control FSM with registered outputs. run_q is updated together with
    // state_q, so o_run always matches the state being entered.
    // Priorities inside RUN:
    //   - Any tick step is applied first.
    //   - A clear pulse then overrides everything: the count and divider go
    //     to zero immediately, so the zero shows up on the same edge as the
    //     state change.
    //   - A run pulse stops the counter but keeps the step that was just
    //     taken. The divider keeps its value, so resuming continues the step
    //     period that was interrupted.
    // The mode toggle is independent of the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= STOP;
            count_q   <= 14'd0;
            divider_q <= '0;
            run_q     <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            if (modePulse) begin
                mode_q <= ~mode_q;
            end

            unique case (state_q)
                STOP: begin
                    if (clearPulse) begin
                        state_q   <= CLEAR;
                        count_q   <= 14'd0;
                        divider_q <= '0;
                        run_q     <= 1'b0;
                    end else if (runPulse) begin
                        state_q <= RUN;
                        run_q   <= 1'b1;
                    end
                end

                RUN: begin
                    if (tick) begin
                        count_q   <= countStep_d;
                        divider_q <= '0;
                    end else begin
                        divider_q <= dividerInc_d;
                    end

                    if (clearPulse) begin
                        state_q   <= CLEAR;
                        count_q   <= 14'd0;
                        divider_q <= '0;
                        run_q     <= 1'b0;
                    end else if (runPulse) begin
                        state_q <= STOP;
                        run_q   <= 1'b0;
                    end
                end

                CLEAR: begin
                    count_q   <= 14'd0;
                    divider_q <= '0;
                    run_q     <= 1'b0;
                    state_q   <= STOP;
                end

                default: begin
                    state_q <= STOP;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_count = count_q;
    assign o_run   = run_q;
    assign o_mode  = mode_q;

endmodule

// File: tb/tb_updown_counter_core.sv
// ---------------------------------------------------------------------------
// tb_updown_counter_core
//
// Self-checking bench for updown_counter_core with a short divider (DIV=4).
// A behavioural reference model tracks the count, run and mode. It works from
// the observable rules:
//   - A button rise is acted on two edges after it is first sampled.
//   - Run toggles, clear zeroes and stops, and mode flips.
//   - Steps occur every DIV running cycles and wrap modulo MAX_COUNT+1.
// The scenario tasks drive the buttons on the falling edge and compare on the
// falling edge. They check both the model and hand-derived timing points.
// ---------------------------------------------------------------------------
module tb_updown_counter_core;

    localparam int DIV       = 4;
    localparam int MAX_COUNT = 9999;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        btnRun   = 1'b0;
    logic        btnClear = 1'b0;
    logic        btnMode  = 1'b0;
    logic [13:0] o_count;
    logic        o_run;
    logic        o_mode;

    int compareCount = 0;
    int failCount    = 0;

    updown_counter_core #(
        .CLK_FREQ (100_000_000),
        .COUNT_HZ (10),
        .DIV      (DIV),
        .MAX_COUNT(MAX_COUNT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_btn_run  (btnRun),
        .i_btn_clear(btnClear),
        .i_btn_mode (btnMode),
        .o_count    (o_count),
        .o_run      (o_run),
        .o_mode     (o_mode)
    );

    // 10 ns system clock
    initial forever #5 clk = ~clk;

    // Safety net so a stuck run still ends with a visible failure
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion before limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model state
    //   - The history vectors hold the button level seen at each of the last
    //     three edges. Index 0 is the newest.
    //   - A press counts as a rise between the samples two and three edges
    //     back.
    //   - mPhase is the number of running cycles since the last step.
    int       mCount    = 0;
    int       mPhase    = 0;
    bit       mRunning  = 1'b0;
    bit       mMode     = 1'b0;
    bit       mClearing = 1'b0;
    bit [2:0] runHist   = '0;
    bit [2:0] clearHist = '0;
    bit [2:0] modeHist  = '0;

    always @(posedge clk) begin : refModel
        bit rp;
        bit cp;
        bit mp;
        int nCount;
        int nPhase;
        bit nRunning;
        bit nClearing;
        bit nMode;
        if (rst) begin
            mCount    <= 0;
            mPhase    <= 0;
            mRunning  <= 1'b0;
            mMode     <= 1'b0;
            mClearing <= 1'b0;
            runHist   <= '0;
            clearHist <= '0;
            modeHist  <= '0;
        end else begin
            rp = runHist[1] && !runHist[2];
            cp = clearHist[1] && !clearHist[2];
            mp = modeHist[1] && !modeHist[2];
            nCount    = mCount;
            nPhase    = mPhase;
            nRunning  = mRunning;
            nClearing = mClearing;
            nMode     = mMode;
            if (mClearing) begin
                nCount    = 0;
                nPhase    = 0;
                nClearing = 1'b0;
            end else begin
                if (mRunning) begin
                    if (mPhase == DIV - 1) begin
                        nPhase = 0;
                        if (mMode) begin
                            nCount = (mCount + MAX_COUNT) % (MAX_COUNT + 1);
                        end else begin
                            nCount = (mCount + 1) % (MAX_COUNT + 1);
                        end
                    end else begin
                        nPhase = mPhase + 1;
                    end
                end
                if (cp) begin
                    nCount    = 0;
                    nPhase    = 0;
                    nClearing = 1'b1;
                    nRunning  = 1'b0;
                end else if (rp) begin
                    nRunning = !mRunning;
                end
            end
            if (mp) begin
                nMode = !mMode;
            end
            mCount    <= nCount;
            mPhase    <= nPhase;
            mRunning  <= nRunning;
            mClearing <= nClearing;
            mMode     <= nMode;
            runHist   <= {runHist[1:0], btnRun};
            clearHist <= {clearHist[1:0], btnClear};
            modeHist  <= {modeHist[1:0], btnMode};
        end
    end

    // Sets the three raw button levels
    task automatic applyStimulus(input logic run, input logic clr, input logic mode);
        btnRun   = run;
        btnClear = clr;
        btnMode  = mode;
    endtask

    // Reset held for three edges, then twenty idle cycles with nothing moving
    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        compareCount++;
        if (o_count !== 14'd0 || o_run !== 1'b0 || o_mode !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_values: got count=%0d run=%b mode=%b, want 0 0 0", o_count, o_run, o_mode);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            compareCount++;
            if (o_count !== 14'd0 || o_run !== 1'b0 || o_mode !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL reset_idle cyc %0d: got count=%0d run=%b mode=%b, want 0 0 0", i, o_count, o_run, o_mode);
            end
        end
    endtask

    // Run press from reset: RUN two edges later, first step four cycles after that
    task automatic test_run_count();
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int j = 1; j <= 45; j++) begin
            @(negedge clk);
            compareCount++;
            if (o_count !== 14'(mCount) || o_run !== mRunning || o_mode !== mMode) begin
                failCount++;
                $display("[TB] FAIL run_count_model j=%0d: got count=%0d run=%b mode=%b, want count=%0d run=%b mode=%b",
                         j, o_count, o_run, o_mode, mCount, mRunning, mMode);
            end
            if (j == 2) begin
                compareCount++;
                if (o_run !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL run_latency_early: got run=%b, want 0", o_run);
                end
            end
            if (j == 3) begin
                applyStimulus(1'b0, 1'b0, 1'b0);
                compareCount++;
                if (o_run !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL run_latency: got run=%b, want 1", o_run);
                end
            end
            if (j == 6) begin
                compareCount++;
                if (o_count !== 14'd0) begin
                    failCount++;
                    $display("[TB] FAIL first_step_early: got count=%0d, want 0", o_count);
                end
            end
            if (j == 7) begin
                compareCount++;
                if (o_count !== 14'd1) begin
                    failCount++;
                    $display("[TB] FAIL first_step: got count=%0d, want 1", o_count);
                end
            end
            if (j == 41) begin
                compareCount++;
                if (o_count !== 14'd9) begin
                    failCount++;
                    $display("[TB] FAIL count_after_40: got count=%0d, want 9", o_count);
                end
            end
        end
    endtask

    // Pause with the divider at 2, wait, resume, then hold the run button
    task automatic test_pause();
        logic [13:0] startCnt;
        logic [13:0] held;
        logic        prevRun;
        bit          found;
        int          toggles;
        startCnt = o_count;
        found    = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (o_count !== startCnt) found = 1'b1;
        end
        compareCount++;
        if (!found) begin
            failCount++;
            $display("[TB] FAIL pause_step_seen: got no step within 12 cycles, want a step");
        end
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b0, 1'b0);
        held = o_count;
        for (int j = 1; j <= 50; j++) begin
            @(negedge clk);
            compareCount++;
            if (o_count !== 14'(mCount) || o_run !== mRunning || o_mode !== mMode) begin
                failCount++;
                $display("[TB] FAIL pause_model j=%0d: got count=%0d run=%b mode=%b, want count=%0d run=%b mode=%b",
                         j, o_count, o_run, o_mode, mCount, mRunning, mMode);
            end
            if (j == 2) begin
                compareCount++;
                if (o_run !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL pause_still_running: got run=%b, want 1", o_run);
                end
            end
            if (j == 3) begin
                applyStimulus(1'b0, 1'b0, 1'b0);
                held = o_count;
                compareCount++;
                if (o_run !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL pause_stopped: got run=%b, want 0", o_run);
                end
            end
            if (j == 50) begin
                compareCount++;
                if (o_count !== held) begin
                    failCount++;
                    $display("[TB] FAIL pause_hold: got count=%0d, want %0d", o_count, held);
                end
            end
        end
        applyStimulus(1'b1, 1'b0, 1'b0);
        prevRun = o_run;
        toggles = 0;
        for (int i = 1; i <= 105; i++) begin
            @(negedge clk);
            compareCount++;
            if (o_count !== 14'(mCount) || o_run !== mRunning || o_mode !== mMode) begin
                failCount++;
                $display("[TB] FAIL resume_model i=%0d: got count=%0d run=%b mode=%b, want count=%0d run=%b mode=%b",
                         i, o_count, o_run, o_mode, mCount, mRunning, mMode);
            end
            if (o_run !== prevRun) toggles++;
            prevRun = o_run;
            if (i == 4) begin
                compareCount++;
                if (o_count !== held) begin
                    failCount++;
                    $display("[TB] FAIL resume_no_early_step: got count=%0d, want %0d", o_count, held);
                end
            end
            if (i == 5) begin
                compareCount++;
                if (o_count !== 14'((int'(held) + 1) % (MAX_COUNT + 1))) begin
                    failCount++;
                    $display("[TB] FAIL resume_first_step: got count=%0d, want %0d", o_count, (int'(held) + 1) % (MAX_COUNT + 1));
                end
            end
            if (i == 100) applyStimulus(1'b0, 1'b0, 1'b0);
        end
        compareCount++;
        if (toggles != 1) begin
            failCount++;
            $display("[TB] FAIL held_run_toggles: got %0d toggles, want 1", toggles);
        end
    endtask

    // Run and clear rising together while running: clear wins
    task automatic test_same_cycle_clear();
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int j = 1; j <= 25; j++) begin
            @(negedge clk);
            compareCount++;
            if (o_count !== 14'(mCount) || o_run !== mRunning || o_mode !== mMode) begin
                failCount++;
                $display("[TB] FAIL clear_model j=%0d: got count=%0d run=%b mode=%b, want count=%0d run=%b mode=%b",
                         j, o_count, o_run, o_mode, mCount, mRunning, mMode);
            end
            if (j == 2) applyStimulus(1'b0, 1'b0, 1'b0);
            if (j >= 3) begin
                compareCount++;
                if (o_count !== 14'd0 || o_run !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL clear_wins j=%0d: got count=%0d run=%b, want count=0 run=0", j, o_count, o_run);
                end
            end
        end
    endtask

    // Down from 0 wraps to MAX_COUNT, then up from MAX_COUNT wraps to 0
    task automatic test_wrap();
        applyStimulus(1'b1, 1'b0, 1'b1);
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            compareCount++;
            if (o_count !== 14'(mCount) || o_run !== mRunning || o_mode !== mMode) begin
                failCount++;
                $display("[TB] FAIL wrap_model j=%0d: got count=%0d run=%b mode=%b, want count=%0d run=%b mode=%b",
                         j, o_count, o_run, o_mode, mCount, mRunning, mMode);
            end
            if (j == 2) applyStimulus(1'b0, 1'b0, 1'b0);
            if (j == 6) begin
                compareCount++;
                if (o_count !== 14'd0 || o_run !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL wrap_pre: got count=%0d run=%b, want count=0 run=1", o_count, o_run);
                end
            end
            if (j == 7) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                compareCount++;
                if (o_count !== 14'(MAX_COUNT) || o_mode !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL wrap_down: got count=%0d mode=%b, want count=%0d mode=1", o_count, o_mode, MAX_COUNT);
                end
            end
            if (j == 8) applyStimulus(1'b0, 1'b0, 1'b0);
            if (j == 10) begin
                compareCount++;
                if (o_count !== 14'(MAX_COUNT) || o_mode !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL wrap_mode_up: got count=%0d mode=%b, want count=%0d mode=0", o_count, o_mode, MAX_COUNT);
                end
            end
            if (j == 11) begin
                compareCount++;
                if (o_count !== 14'd0) begin
                    failCount++;
                    $display("[TB] FAIL wrap_up: got count=%0d, want 0", o_count);
                end
            end
        end
    endtask

    // Count up to 37, switch to down, then reset in the middle of counting
    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            compareCount++;
            if (o_count !== 14'(mCount) || o_run !== mRunning || o_mode !== mMode) begin
                failCount++;
                $display("[TB] FAIL to37_model i=%0d: got count=%0d run=%b mode=%b, want count=%0d run=%b mode=%b",
                         i, o_count, o_run, o_mode, mCount, mRunning, mMode);
            end
            if (o_count == 14'd37) found = 1'b1;
        end
        compareCount++;
        if (!found) begin
            failCount++;
            $display("[TB] FAIL reach_37: got count=%0d after 400 cycles, want 37", o_count);
            return;
        end
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        compareCount++;
        if (o_count !== 14'd37 || o_mode !== 1'b1 || o_run !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL pre_reset_state: got count=%0d mode=%b run=%b, want count=37 mode=1 run=1", o_count, o_mode, o_run);
        end
        rst = 1'b1;
        @(negedge clk);
        compareCount++;
        if (o_count !== 14'd0 || o_run !== 1'b0 || o_mode !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mid_reset: got count=%0d run=%b mode=%b, want 0 0 0", o_count, o_run, o_mode);
        end
        rst = 1'b0;
    endtask

    // Random button activity with occasional resets, checked against the model
    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            compareCount++;
            if (o_count !== 14'(mCount) || o_run !== mRunning || o_mode !== mMode) begin
                failCount++;
                $display("[TB] FAIL random_model i=%0d: got count=%0d run=%b mode=%b, want count=%0d run=%b mode=%b",
                         i, o_count, o_run, o_mode, mCount, mRunning, mMode);
            end
            if ($urandom_range(7) == 0) btnRun = ~btnRun;
            if ($urandom_range(15) == 0) btnClear = ~btnClear;
            if ($urandom_range(9) == 0) btnMode = ~btnMode;
            rst = ($urandom_range(149) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        $display("[TB] updown_counter_core bench start");
        test_reset();
        test_run_count();
        test_pause();
        test_same_cycle_clear();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
